// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, computes at acceptance and
// emulates the multi-cycle latency with a down-counter.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Req,
   input  logic [3:0]  MDUOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Start,
   output logic        Busy,
   output logic [31:0] MDUOut,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV  = 4'd3, OP_DIVU = 4'd4,
      OP_MTHI  = 4'd5, OP_MTLO = 4'd6, OP_MFHI  = 4'd7, OP_MFLO = 4'd8
   } mdu_op_e;

   typedef enum logic {IDLE, RUN} state_e;

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   state_e            state, state_nx;
   logic [CW-1:0]     count;
   logic [31:0]       pend_hi, pend_lo;
   logic              pend_wr;
   logic              is_muldiv, accept_md, last;

   logic [31:0]       b_nz, q_u, r_u;
   logic signed [31:0] a_s, b_s, q_s, r_s;
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;

   assign is_muldiv = (MDUOp >= 4'd1) && (MDUOp <= 4'd4);
   assign accept_md = Start && (state == IDLE);
   assign last      = (state == RUN) && (count == CW'(1));

   // Divisor forced nonzero so the divider never sees 0; a zero divide skips the commit.
   always_comb begin
      b_nz   = (B == 32'd0) ? 32'd1 : B;
      a_s    = $signed(A);
      b_s    = $signed(b_nz);
      prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
      prod_u = {32'd0, A} * {32'd0, B};
      q_u    = A / b_nz;
      r_u    = A % b_nz;
      if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
         q_s = a_s;
         r_s = '0;
      end else begin
         q_s = a_s / b_s;
         r_s = a_s % b_s;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept_md) state_nx = RUN;
         RUN:     if (last)      state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      Start  = is_muldiv && !Req;
      Busy   = (state == RUN);
      MDUOut = '0;
      if (MDUOp == OP_MFHI)      MDUOut = HI;
      else if (MDUOp == OP_MFLO) MDUOut = LO;
   end

   // NOTE: all state here uses non-blocking assignment so HI/LO, counter and
   // pending values update together at the edge regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count   <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_wr <= 1'b0;
         HI      <= '0;
         LO      <= '0;
      end else if (state == RUN) begin
         count <= count - CW'(1);
         if (last && pend_wr) begin
            HI <= pend_hi;
            LO <= pend_lo;
         end
      end else if (!Req) begin
         case (MDUOp)
            OP_MULT: begin
               count              <= CW'(MULT_CYCLES);
               {pend_hi, pend_lo} <= $unsigned(prod_s);
               pend_wr            <= 1'b1;
            end
            OP_MULTU: begin
               count              <= CW'(MULT_CYCLES);
               {pend_hi, pend_lo} <= prod_u;
               pend_wr            <= 1'b1;
            end
            OP_DIV: begin
               count   <= CW'(DIV_CYCLES);
               pend_hi <= $unsigned(r_s);
               pend_lo <= $unsigned(q_s);
               pend_wr <= (B != 32'd0);
            end
            OP_DIVU: begin
               count   <= CW'(DIV_CYCLES);
               pend_hi <= r_u;
               pend_lo <= q_u;
               pend_wr <= (B != 32'd0);
            end
            OP_MTHI: HI <= A;
            OP_MTLO: LO <= A;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: table of ops with a HI/LO scoreboard,
// plus hand-written sequences for Req, busy-time ops and mid-run reset.
module tb_e_mdu;

   localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4,
                          MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7, MFLO = 4'd8;

   logic        clk = 1'b0;
   logic        reset, Req;
   logic [3:0]  MDUOp;
   logic [31:0] A, B;
   logic        Start, Busy;
   logic [31:0] MDUOut, HI, LO;

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .Req(Req), .MDUOp(MDUOp), .A(A), .B(B),
      .Start(Start), .Busy(Busy), .MDUOut(MDUOut), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b;
      int          cycles;
      logic [31:0] hi, lo;
   } vec_t;

   typedef struct {
      logic [31:0] hi, lo;
   } exp_t;

   vec_t vecs[13];
   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive an op for one cycle and queue the HI/LO it must eventually produce.
   task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] hi, input logic [31:0] lo);
      exp_t e;
      @(negedge clk);
      Req = 1'b0; MDUOp = op; A = a; B = b;
      #1 check("start", {31'd0, Start}, {31'd0, (op >= MULT && op <= DIVU)});
      @(posedge clk);
      #1 MDUOp = NONE;
      e.hi = hi; e.lo = lo;
      sb.push_back(e);
   endtask

   // Count Busy samples (bounded) then pop the scoreboard and compare HI/LO.
   task automatic finish_op(input string name, input int n, input int seen_in);
      exp_t e;
      int seen = seen_in;
      if (n == 0) begin
         check({name, "_busy"}, {31'd0, Busy}, 32'd0);
      end else begin
         while (Busy && seen < n + 5) begin
            @(posedge clk);
            #1 if (Busy) seen++;
         end
         check({name, "_busy_cycles"}, seen, n);
      end
      if (sb.size() == 0) begin
         check({name, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({name, "_hi"}, HI, e.hi);
         check({name, "_lo"}, LO, e.lo);
      end
   endtask

   initial begin
      vecs[0]  = '{MULT,  32'hFFFF_FFFD, 32'h0000_0005, 5,  32'hFFFF_FFFF, 32'hFFFF_FFF1};
      vecs[1]  = '{MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'h0000_0001, 32'hFFFF_FFFE};
      vecs[2]  = '{DIV,   32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3]  = '{DIVU,  32'h8000_0000, 32'h0000_0010, 10, 32'h0000_0000, 32'h0800_0000};
      vecs[4]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
      vecs[5]  = '{DIV,   32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
      vecs[6]  = '{MULT,  32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000};
      vecs[7]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001};
      vecs[8]  = '{DIVU,  32'hFFFF_FFFF, 32'h0000_0003, 10, 32'h0000_0000, 32'h5555_5555};
      vecs[9]  = '{MTHI,  32'h1234_5678, 32'h0000_0000, 0,  32'h1234_5678, 32'h5555_5555};
      vecs[10] = '{MTLO,  32'h9ABC_DEF0, 32'h0000_0000, 0,  32'h1234_5678, 32'h9ABC_DEF0};
      vecs[11] = '{DIV,   32'h0000_0005, 32'h0000_0000, 10, 32'h1234_5678, 32'h9ABC_DEF0};
      vecs[12] = '{4'd9,  32'hDEAD_BEEF, 32'h0000_0000, 0,  32'h1234_5678, 32'h9ABC_DEF0};

      reset = 1'b1; Req = 1'b0; MDUOp = NONE; A = '0; B = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      check("rst_busy", {31'd0, Busy}, 32'd0);
      @(negedge clk) reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
         if (vecs[i].cycles > 0) check($sformatf("v%0d_busy_on", i), {31'd0, Busy}, 32'd1);
         finish_op($sformatf("v%0d", i), vecs[i].cycles, 1);
         @(negedge clk);
         MDUOp = MFLO;
         #1 check($sformatf("v%0d_mflo", i), MDUOut, vecs[i].lo);
         MDUOp = MFHI;
         #1 check($sformatf("v%0d_mfhi", i), MDUOut, vecs[i].hi);
         MDUOp = NONE;
         #1 check($sformatf("v%0d_out_none", i), MDUOut, 32'd0);
      end

      // mult with Req=1 is discarded.
      @(negedge clk);
      Req = 1'b1; MDUOp = MULT; A = 32'd3; B = 32'd4;
      #1 check("req_start", {31'd0, Start}, 32'd0);
      @(posedge clk);
      #1 check("req_busy", {31'd0, Busy}, 32'd0);
      check("req_hi", HI, 32'h1234_5678);
      check("req_lo", LO, 32'h9ABC_DEF0);
      Req = 1'b0; MDUOp = NONE;

      // In-flight mult ignores new ops and Req, and still commits.
      start_op(MULT, 32'd3, 32'd4, 32'd0, 32'd12);
      @(negedge clk);
      MDUOp = MULT; A = 32'd100; B = 32'd100;
      #1 check("run_start_indep", {31'd0, Start}, 32'd1);
      @(posedge clk);
      #1 check("run_busy2", {31'd0, Busy}, 32'd1);
      Req = 1'b1; MDUOp = MTLO; A = 32'h0000_FFFF;
      @(posedge clk);
      #1 check("run_busy3", {31'd0, Busy}, 32'd1);
      check("run_lo_held", LO, 32'h9ABC_DEF0);
      Req = 1'b0; MDUOp = NONE;
      finish_op("run_req", 5, 3);

      // Async reset at cycle 3 of a div aborts without commit.
      start_op(DIV, 32'd100, 32'd7, 32'd2, 32'd14);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      #1;
      check("mid_rst_busy", {31'd0, Busy}, 32'd0);
      check("mid_rst_hi", HI, 32'd0);
      check("mid_rst_lo", LO, 32'd0);
      sb.delete();
      @(negedge clk) reset = 1'b0;

      start_op(MULT, 32'd6, 32'd7, 32'd0, 32'd42);
      check("post_rst_busy_on", {31'd0, Busy}, 32'd1);
      finish_op("post_rst", 5, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
